// File: rtl/tt_um_array_div_seq_gnahslliw.sv
// rtl/tt_um_array_div_seq_gnahslliw.sv - 8/4-bit sequential restoring divider (optional DIV_ZERO_FAST_EN)
module tt_um_array_div_seq_gnahslliw (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ZDIV = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       start_q;
    logic       start_edge;
    logic       load;
    logic       zero_fast;
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] pr;
    logic [7:0] quo;
    logic [2:0] cnt;
    logic [8:0] pr_sh;
    logic       fits;
    logic [7:0] pr_nx;
    logic       unused;

    assign unused     = &{1'b0, uio_in[7:6]};
    assign start_edge = uio_in[4] & ~start_q;

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (uio_in[3:0] == 4'd0);
`else
    assign zero_fast = 1'b0;
`endif

    // 9-bit trial value; the kept remainder is always below 256 so 8 bits are stored
    assign pr_sh = {pr, dvd[7]};
    assign fits  = (pr_sh >= {5'b0, dvs});
    assign pr_nx = fits ? 8'(pr_sh - {5'b0, dvs}) : pr_sh[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    load     = 1'b1;
                    state_nx = zero_fast ? ZDIV : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 3'd7) begin
                    state_nx = DONE;
                end
            end
            ZDIV: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            dvd     <= 8'd0;
            dvs     <= 4'd0;
            pr      <= 8'd0;
            quo     <= 8'd0;
            cnt     <= 3'd0;
        end else if (ena) begin
            start_q <= uio_in[4];
            if (load) begin
                dvd <= ui_in;
                dvs <= uio_in[3:0];
                cnt <= 3'd0;
                if (zero_fast) begin
                    pr  <= ui_in;
                    quo <= 8'hFF;
                end else begin
                    pr  <= 8'd0;
                    quo <= 8'd0;
                end
            end else if (state == BUSY) begin
                dvd <= {dvd[6:0], 1'b0};
                pr  <= pr_nx;
                quo <= {quo[6:0], fits};
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign uo_out  = uio_in[5] ? pr : quo;
    assign uio_out = {(state == DONE), (state == BUSY), 6'b0};
    assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_array_div_seq_gnahslliw.sv
// tb/tb_tt_um_array_div_seq_gnahslliw.sv - scoreboard bench for the sequential divider
module tb_tt_um_array_div_seq_gnahslliw;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        int         lat;
        int         busy_cyc;
    } exp_t;

    exp_t sb[$];

    tt_um_array_div_seq_gnahslliw dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           input int freeze_at, input bit held, input string tag);
        exp_t e;
        exp_t got;
        int   cyc;
        int   bcnt;
        bit   fast;
        fast = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        fast = (b == 4'd0);
`endif
        e.q        = (b == 0) ? 8'hFF : a / {4'd0, b};
        e.r        = (b == 0) ? a : a % {4'd0, b};
        e.lat      = fast ? 1 : (8 + (freeze_at > 0 ? 3 : 0));
        e.busy_cyc = fast ? 0 : e.lat;
        sb.push_back(e);

        @(negedge clk);
        ui_in  = a;
        uio_in = {2'b00, 1'b0, 1'b1, b};
        @(negedge clk);
        if (!held) uio_in[4] = 1'b0;
        cyc  = 0;
        bcnt = 0;
        while (!uio_out[7] && cyc < 40) begin
            bcnt += int'(uio_out[6]);
            if (freeze_at > 0 && cyc == freeze_at)     ena = 1'b0;
            if (freeze_at > 0 && cyc == freeze_at + 3) ena = 1'b1;
            if (held && cyc == 3) begin
                ui_in       = ~a;
                uio_in[3:0] = b + 4'd1;
            end
            if (held && cyc == 4) uio_in[4] = 1'b0;
            if (held && cyc == 5) uio_in[4] = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (held) begin
            repeat (12) @(negedge clk);
            check({tag, " held_done"}, int'(uio_out[7]), 1);
            check({tag, " held_busy"}, int'(uio_out[6]), 0);
            uio_in[4] = 1'b0;
        end

        got = sb.pop_front();
        check({tag, " latency"}, cyc, got.lat);
        check({tag, " busy_cycles"}, bcnt, got.busy_cyc);
        uio_in[5] = 1'b0;
        #1;
        check({tag, " quotient"}, int'(uo_out), int'(got.q));
        uio_in[5] = 1'b1;
        #1;
        check({tag, " remainder"}, int'(uo_out), int'(got.r));
        check({tag, " uio_out_low"}, int'(uio_out[5:0]), 0);
        uio_in[5] = 1'b0;
    endtask

    initial begin
        #12;
        check("reset uo_out", int'(uo_out), 0);
        check("reset uio_out", int'(uio_out), 0);
        check("uio_oe", int'(uio_oe), 8'hC0);
        rst_n = 1'b1;

        // abort mid-run with reset
        @(negedge clk);
        ui_in  = 8'd200;
        uio_in = {4'b0001, 4'd7};
        @(negedge clk);
        uio_in[4] = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-abort busy", int'(uio_out[6]), 1);
        rst_n = 1'b0;
        #1;
        check("abort uo_out q", int'(uo_out), 0);
        uio_in[5] = 1'b1;
        #1;
        check("abort uo_out r", int'(uo_out), 0);
        uio_in[5] = 1'b0;
        check("abort busy", int'(uio_out[6]), 0);
        check("abort done", int'(uio_out[7]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div(8'd200, 4'd7, 0, 1'b0, "200/7");
        run_div(8'd255, 4'd15, 0, 1'b0, "255/15");
        run_div(8'd0, 4'd9, 0, 1'b0, "0/9");
        run_div(8'd5, 4'd9, 0, 1'b0, "5/9");
        run_div(8'd255, 4'd1, 0, 1'b0, "255/1");
        run_div(8'hA5, 4'd0, 0, 1'b0, "A5/0");
        run_div(8'd100, 4'd3, 0, 1'b1, "held 100/3");
        run_div(8'd200, 4'd7, 3, 1'b0, "ena freeze 200/7");
        for (int i = 0; i < 6; i++) begin
            run_div(8'($urandom_range(0, 255)), 4'($urandom_range(1, 15)), 0, 1'b0, "random");
        end

        check("scoreboard empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
